seg7_capture_decoder: RTL and testbench
=======================================

Name: seg7_capture_decoder

Overview:
- Inverse of the BCD-to-7-segment encoder: samples two 9-bit segment buses {SEG,DP,G,F,E,D,C,B,A} (tens, ones) and recovers the two 4-bit digit codes.
- Used for loopback self-check of the display path and for reading external 7-segment drivers.
- Inputs are asynchronous. They are synchronised, filtered for stability, then decoded. A digit pair is reported once per distinct stable pattern.

Parameters:
- COMMON_ANODE, 1'b0, 1 means the segment bits are active-low and the common bit is expected to be 1; 0 means active-high segments with the common bit expected to be 0.
- STABLE_CYCLES, 16, number of consecutive identical synchronised samples required before a report (legal range 2..65535).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- segment_led_tens_in  input  9  tens bus, MSB..LSB = SEG,DP,G,F,E,D,C,B,A.
- segment_led_ones_in  input  9  ones bus, same format.
- bcd_tens_out  output  4  last valid decoded tens code.
- bcd_ones_out  output  4  last valid decoded ones code.
- code_valid  output  1  one-cycle pulse when new valid codes are loaded.
- code_err  output  1  level; high while the last report was invalid.

Behaviour:
- Reset (async, rst_n=0): bcd_tens_out=0, bcd_ones_out=0, code_valid=0, code_err=0, sync stages=0, counter=0, state=WAIT, have_reported=0. Reset mid-operation aborts immediately and no pending report survives.
- Synchronisation: each 18-bit input pair passes through two flops. The second stage is the sample S.
- Normalisation per channel:
  - If COMMON_ANODE=1, invert bits[6:0].
  - The DP bit is ignored.
  - A common bit that differs from the expected value marks the channel invalid.
- Lookup (7-bit GFEDCBA to value):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Every other pattern, including blank 0x00, is invalid (hex patterns: see Optional Feature).
- Snapshot P is the 18-bit S. The counter compares P with the previous P each cycle: mismatch → counter=0; match → counter increments, saturating at STABLE_CYCLES-1.
- State WAIT:
  - When the counter reaches STABLE_CYCLES-1 and (have_reported=0 or P≠last_reported_P) → REPORT.
  - If the counter saturates and P equals last_reported_P → HOLD, with no report. This covers a glitch that reverts to the old value.
- State REPORT (1 cycle), then → HOLD:
  - Latch last_reported_P=P and set have_reported=1.
  - Both channels valid: load bcd outputs, code_valid=1 for this cycle, code_err=0.
  - Either channel invalid: bcd outputs unchanged, code_valid=0, code_err=1.
- State HOLD: on any change of P → WAIT with counter=0.
- Latency: input change to code_valid is 2 (sync) + STABLE_CYCLES + 1 cycles.
- A change on either channel restarts the filter for both. The pair is always reported atomically.

Optional Feature:
- Macro: SEG7_CAPTURE_HEX_EN.
- Defined: patterns 0x77→10, 0x7C→11, 0x39→12, 0x5E→13, 0x79→14, 0x71→15 decode as valid.
- Undefined: those six patterns are invalid and produce code_err.

Decomposition:
- Shared package seg7_pkg:
  - localparam pattern constants SEG7_PAT_0..SEG7_PAT_F (7-bit GFEDCBA).
  - Bit-index constants SEG7_IDX_SEG=8 and SEG7_IDX_DP=7.
  - State encoding constants WAIT, REPORT, HOLD.
  - The encoder module is also updated to use these constants.
- Sub-module seg7_lookup: combinational normalise+lookup, inputs 9-bit bus and COMMON_ANODE, outputs 4-bit value and valid. Instantiated twice (tens, ones). Honours SEG7_CAPTURE_HEX_EN.

Test Plan:
- CC mode, STABLE_CYCLES=16: tens=9'h03F, ones=9'h006 held from cycle 0 → code_valid pulses once at cycle 19, bcd_tens_out=0, bcd_ones_out=1, code_err=0. No further pulse while held.
- Glitch: after the report above, ones=9'h05B for 5 cycles then back to 9'h006 → no code_valid, outputs unchanged.
- New value: ones→9'h04F held 20 cycles → one pulse, bcd_ones_out=3.
- Invalid inputs:
  - Tens=9'h13F (common bit wrong for CC) held → code_err=1, bcd outputs keep the prior values, no pulse.
  - Then tens=9'h07F → pulse, bcd_tens_out=8, code_err=0.
- Hex: ones=9'h077 held:
  - With SEG7_CAPTURE_HEX_EN → pulse, bcd_ones_out=10.
  - Without the macro → code_err=1.
- CA mode (COMMON_ANODE=1): tens=9'h140, ones=9'h179 → decode 0 and 1. Assert rst_n=0 at cycle 10 of the filter → all outputs 0. After release, the same stable input reports 19 cycles later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: GFEDCBA patterns, bus bit positions, capture FSM
// state encoding and the tens/ones bus pair payload.
package seg7_pkg;

  localparam int unsigned SEG7_BUS_W   = 9;
  localparam int unsigned SEG7_PAT_W   = 7;
  localparam int unsigned SEG7_BCD_W   = 4;
  localparam int unsigned SEG7_IDX_SEG = 8;
  localparam int unsigned SEG7_IDX_DP  = 7;

  // Active-high GFEDCBA patterns for 0..F
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_0 = 7'h3F;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_1 = 7'h06;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_2 = 7'h5B;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_3 = 7'h4F;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_4 = 7'h66;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_5 = 7'h6D;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_6 = 7'h7D;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_7 = 7'h07;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_8 = 7'h7F;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_9 = 7'h6F;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_A = 7'h77;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_B = 7'h7C;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_C = 7'h39;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_D = 7'h5E;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_E = 7'h79;
  localparam logic [SEG7_PAT_W-1:0] SEG7_PAT_F = 7'h71;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } seg7_state_e;

  typedef struct packed {
    logic [SEG7_BUS_W-1:0] tens;
    logic [SEG7_BUS_W-1:0] ones;
  } seg7_pair_t;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational normalise + decode of one 9-bit {SEG,DP,GFEDCBA} bus to a digit.
// Hex digits A..F decode as valid only when SEG7_CAPTURE_HEX_EN is defined.
module seg7_lookup
  import seg7_pkg::*;
#(
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic [SEG7_BUS_W-1:0] i_bus,
  output logic [SEG7_BCD_W-1:0] o_value_c,
  output logic                  o_valid_c
);

`ifdef SEG7_CAPTURE_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  logic [SEG7_PAT_W-1:0] w_seg;
  logic                  w_common_ok;
  logic                  w_pat_ok;
  logic                  w_unused_dp;

  assign w_seg       = COMMON_ANODE ? ~i_bus[SEG7_PAT_W-1:0] : i_bus[SEG7_PAT_W-1:0];
  assign w_common_ok = (i_bus[SEG7_IDX_SEG] == COMMON_ANODE);
  assign w_unused_dp = i_bus[SEG7_IDX_DP];

  always_comb begin
    o_value_c = '0;
    w_pat_ok  = 1'b1;
    case (w_seg)
      SEG7_PAT_0: o_value_c = 4'd0;
      SEG7_PAT_1: o_value_c = 4'd1;
      SEG7_PAT_2: o_value_c = 4'd2;
      SEG7_PAT_3: o_value_c = 4'd3;
      SEG7_PAT_4: o_value_c = 4'd4;
      SEG7_PAT_5: o_value_c = 4'd5;
      SEG7_PAT_6: o_value_c = 4'd6;
      SEG7_PAT_7: o_value_c = 4'd7;
      SEG7_PAT_8: o_value_c = 4'd8;
      SEG7_PAT_9: o_value_c = 4'd9;
      SEG7_PAT_A: begin o_value_c = 4'd10; w_pat_ok = HEX_EN; end
      SEG7_PAT_B: begin o_value_c = 4'd11; w_pat_ok = HEX_EN; end
      SEG7_PAT_C: begin o_value_c = 4'd12; w_pat_ok = HEX_EN; end
      SEG7_PAT_D: begin o_value_c = 4'd13; w_pat_ok = HEX_EN; end
      SEG7_PAT_E: begin o_value_c = 4'd14; w_pat_ok = HEX_EN; end
      SEG7_PAT_F: begin o_value_c = 4'd15; w_pat_ok = HEX_EN; end
      default:    w_pat_ok = 1'b0;
    endcase
  end

  assign o_valid_c = w_common_ok && w_pat_ok;

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples two asynchronous 7-segment buses, filters for stability and reports the
// decoded digit pair once per distinct stable pattern. Hex decode: SEG7_CAPTURE_HEX_EN.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter bit          COMMON_ANODE  = 1'b0,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG7_BUS_W-1:0] segment_led_tens_in,
  input  logic [SEG7_BUS_W-1:0] segment_led_ones_in,
  output logic [SEG7_BCD_W-1:0] bcd_tens_out,
  output logic [SEG7_BCD_W-1:0] bcd_ones_out,
  output logic                  code_valid,
  output logic                  code_err
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  seg7_pair_t            r_sync1;
  seg7_pair_t            r_sync2;
  seg7_pair_t            r_prev;
  seg7_pair_t            r_last;
  logic [CNT_W-1:0]      r_cnt;
  seg7_state_e           r_state;
  seg7_state_e           w_state_nxt;
  logic                  r_have;
  logic                  w_have_nxt;
  logic [SEG7_BCD_W-1:0] r_tens;
  logic [SEG7_BCD_W-1:0] w_tens_nxt;
  logic [SEG7_BCD_W-1:0] r_ones;
  logic [SEG7_BCD_W-1:0] w_ones_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  w_latch;
  logic                  w_change;
  logic                  w_cnt_clr;
  logic [SEG7_BCD_W-1:0] w_tens_val;
  logic [SEG7_BCD_W-1:0] w_ones_val;
  logic                  w_tens_ok;
  logic                  w_ones_ok;

  // Decode the pair the counter has qualified, not the newest sample
  seg7_lookup #(.COMMON_ANODE(COMMON_ANODE)) u_lookup_tens (
    .i_bus     (r_prev.tens),
    .o_value_c (w_tens_val),
    .o_valid_c (w_tens_ok)
  );

  seg7_lookup #(.COMMON_ANODE(COMMON_ANODE)) u_lookup_ones (
    .i_bus     (r_prev.ones),
    .o_value_c (w_ones_val),
    .o_valid_c (w_ones_ok)
  );

  assign w_change  = (r_sync2 != r_prev);
  assign w_cnt_clr = w_change || ((r_state == HOLD) && (w_state_nxt == WAIT));

  // Two-flop synchroniser and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {segment_led_tens_in, segment_led_ones_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
      r_have  <= 1'b0;
      r_last  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_have  <= w_have_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_last <= r_prev;
      end
    end
  end

  // Report effects are registered on entry to REPORT so they are visible during it
  always_comb begin
    w_state_nxt = r_state;
    w_have_nxt  = r_have;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    case (r_state)
      WAIT: begin
        if (r_cnt == CNT_MAX) begin
          if (!r_have || (r_prev != r_last)) begin
            w_state_nxt = REPORT;
            w_latch     = 1'b1;
            w_have_nxt  = 1'b1;
            if (w_tens_ok && w_ones_ok) begin
              w_tens_nxt  = w_tens_val;
              w_ones_nxt  = w_ones_val;
              w_valid_nxt = 1'b1;
              w_err_nxt   = 1'b0;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      REPORT: w_state_nxt = HOLD;
      HOLD: begin
        // Also leave if the pattern moved while the report was in flight
        if (w_change || (r_prev != r_last)) begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  assign bcd_tens_out = r_tens;
  assign bcd_ones_out = r_ones;
  assign code_valid   = r_valid;
  assign code_err     = r_err;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: a common-cathode and a common-anode
// instance, STABLE_CYCLES=16, checked against hand-computed expectations.
module tb_seg7_capture_decoder;

  logic       clk;
  logic       rst_n;
  logic       ca_rst_n;
  logic [8:0] cc_tens, cc_ones, ca_tens, ca_ones;
  logic [3:0] cc_bt, cc_bo, ca_bt, ca_bo;
  logic       cc_valid, cc_err, ca_valid, ca_err;

  int checks = 0;
  int errors = 0;

  int p_cc, f_cc, e_cc, p_ca, f_ca;

  seg7_capture_decoder #(.COMMON_ANODE(1'b0), .STABLE_CYCLES(16)) u_cc (
    .clk                 (clk),
    .rst_n               (rst_n),
    .segment_led_tens_in (cc_tens),
    .segment_led_ones_in (cc_ones),
    .bcd_tens_out        (cc_bt),
    .bcd_ones_out        (cc_bo),
    .code_valid          (cc_valid),
    .code_err            (cc_err)
  );

  seg7_capture_decoder #(.COMMON_ANODE(1'b1), .STABLE_CYCLES(16)) u_ca (
    .clk                 (clk),
    .rst_n               (ca_rst_n),
    .segment_led_tens_in (ca_tens),
    .segment_led_ones_in (ca_ones),
    .bcd_tens_out        (ca_bt),
    .bcd_ones_out        (ca_bo),
    .code_valid          (ca_valid),
    .code_err            (ca_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, sampling 1ns after each edge; cycle 1 is the first edge.
  task automatic run_window(input int n);
    p_cc = 0; f_cc = -1; e_cc = -1; p_ca = 0; f_ca = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (cc_valid) begin p_cc++; if (f_cc < 0) f_cc = i; end
      if (ca_valid) begin p_ca++; if (f_ca < 0) f_ca = i; end
      if (cc_err && e_cc < 0) e_cc = i;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ca_rst_n = 1'b0;
    cc_tens = 9'h03F; cc_ones = 9'h006;
    ca_tens = 9'h110; ca_ones = 9'h100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cc_bt, cc_bo, cc_valid, cc_err} !== 10'd0) begin
      errors++; $display("FAIL reset_cc got %h want 000", {cc_bt, cc_bo, cc_valid, cc_err});
    end
    checks++;
    if ({ca_bt, ca_bo, ca_valid, ca_err} !== 10'd0) begin
      errors++; $display("FAIL reset_ca got %h want 000", {ca_bt, ca_bo, ca_valid, ca_err});
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    rst_n = 1'b1; ca_rst_n = 1'b1;
    run_window(30);
    checks++;
    if (p_cc != 1 || f_cc != 19) begin
      errors++; $display("FAIL basic_pulse got count %0d at %0d want 1 at 19", p_cc, f_cc);
    end
    checks++;
    if (cc_bt !== 4'd0 || cc_bo !== 4'd1 || cc_err !== 1'b0) begin
      errors++; $display("FAIL basic_codes got %0d/%0d err %b want 0/1 err 0", cc_bt, cc_bo, cc_err);
    end
    checks++;
    if (p_ca != 1 || f_ca != 19 || ca_bt !== 4'd9 || ca_bo !== 4'd8) begin
      errors++; $display("FAIL basic_ca got count %0d at %0d codes %0d/%0d want 1 at 19 codes 9/8",
                         p_ca, f_ca, ca_bt, ca_bo);
    end
    run_window(20);
    checks++;
    if (p_cc != 0) begin
      errors++; $display("FAIL basic_hold got %0d pulses want 0", p_cc);
    end
  endtask

  task automatic test_glitch;
    cc_ones = 9'h05B;
    run_window(5);
    checks++;
    if (p_cc != 0) begin
      errors++; $display("FAIL glitch_during got %0d pulses want 0", p_cc);
    end
    cc_ones = 9'h006;
    run_window(30);
    checks++;
    if (p_cc != 0 || cc_bt !== 4'd0 || cc_bo !== 4'd1 || cc_err !== 1'b0) begin
      errors++; $display("FAIL glitch_revert got %0d pulses codes %0d/%0d err %b want 0 pulses 0/1 err 0",
                         p_cc, cc_bt, cc_bo, cc_err);
    end
  endtask

  task automatic test_new_value;
    cc_ones = 9'h04F;
    run_window(20);
    checks++;
    if (p_cc != 1 || f_cc != 19) begin
      errors++; $display("FAIL new_pulse got count %0d at %0d want 1 at 19", p_cc, f_cc);
    end
    checks++;
    if (cc_bt !== 4'd0 || cc_bo !== 4'd3) begin
      errors++; $display("FAIL new_codes got %0d/%0d want 0/3", cc_bt, cc_bo);
    end
  endtask

  task automatic test_invalid;
    cc_tens = 9'h13F;
    run_window(20);
    checks++;
    if (p_cc != 0 || e_cc != 19) begin
      errors++; $display("FAIL invalid_err got pulses %0d err rise %0d want 0 and 19", p_cc, e_cc);
    end
    checks++;
    if (cc_bt !== 4'd0 || cc_bo !== 4'd3 || cc_err !== 1'b1) begin
      errors++; $display("FAIL invalid_keep got %0d/%0d err %b want 0/3 err 1", cc_bt, cc_bo, cc_err);
    end
    cc_tens = 9'h07F;
    run_window(20);
    checks++;
    if (p_cc != 1 || f_cc != 19 || cc_bt !== 4'd8 || cc_bo !== 4'd3 || cc_err !== 1'b0) begin
      errors++; $display("FAIL invalid_recover got %0d at %0d codes %0d/%0d err %b want 1 at 19 8/3 err 0",
                         p_cc, f_cc, cc_bt, cc_bo, cc_err);
    end
  endtask

  task automatic test_hex;
    cc_ones = 9'h077;
    run_window(20);
`ifdef SEG7_CAPTURE_HEX_EN
    checks++;
    if (p_cc != 1 || f_cc != 19 || cc_bt !== 4'd8 || cc_bo !== 4'd10 || cc_err !== 1'b0) begin
      errors++; $display("FAIL hex_on got %0d at %0d codes %0d/%0d err %b want 1 at 19 8/10 err 0",
                         p_cc, f_cc, cc_bt, cc_bo, cc_err);
    end
`else
    checks++;
    if (p_cc != 0 || cc_bt !== 4'd8 || cc_bo !== 4'd3 || cc_err !== 1'b1) begin
      errors++; $display("FAIL hex_off got %0d pulses codes %0d/%0d err %b want 0 pulses 8/3 err 1",
                         p_cc, cc_bt, cc_bo, cc_err);
    end
`endif
  endtask

  task automatic test_restart;
    cc_tens = 9'h06D; cc_ones = 9'h07D;
    run_window(10);
    checks++;
    if (p_cc != 0) begin
      errors++; $display("FAIL restart_early got %0d pulses want 0", p_cc);
    end
    cc_ones = 9'h007;
    run_window(20);
    checks++;
    if (p_cc != 1 || f_cc != 19 || cc_bt !== 4'd5 || cc_bo !== 4'd7 || cc_err !== 1'b0) begin
      errors++; $display("FAIL restart_pair got %0d at %0d codes %0d/%0d err %b want 1 at 19 5/7 err 0",
                         p_cc, f_cc, cc_bt, cc_bo, cc_err);
    end
  endtask

  task automatic test_ca_reset;
    checks++;
    if (ca_bt !== 4'd9 || ca_bo !== 4'd8 || ca_err !== 1'b0) begin
      errors++; $display("FAIL ca_prior got %0d/%0d err %b want 9/8 err 0", ca_bt, ca_bo, ca_err);
    end
    ca_tens = 9'h140; ca_ones = 9'h179;
    run_window(10);
    checks++;
    if (p_ca != 0) begin
      errors++; $display("FAIL ca_early got %0d pulses want 0", p_ca);
    end
    ca_rst_n = 1'b0;
    #1;
    checks++;
    if ({ca_bt, ca_bo, ca_valid, ca_err} !== 10'd0) begin
      errors++; $display("FAIL ca_abort got %h want 000", {ca_bt, ca_bo, ca_valid, ca_err});
    end
    @(negedge clk);
    ca_rst_n = 1'b1;
    run_window(30);
    checks++;
    if (p_ca != 1 || f_ca != 19) begin
      errors++; $display("FAIL ca_pulse got count %0d at %0d want 1 at 19", p_ca, f_ca);
    end
    checks++;
    if (ca_bt !== 4'd0 || ca_bo !== 4'd1 || ca_err !== 1'b0) begin
      errors++; $display("FAIL ca_codes got %0d/%0d err %b want 0/1 err 0", ca_bt, ca_bo, ca_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_new_value();
    test_invalid();
    test_hex();
    test_restart();
    test_ca_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
